// File: rtl/bp_be_nr_regfile.sv
// Multi-port backend register file with stall re-read and write forwarding.
// Define BP_BE_NR_REGFILE_SCRUB_EN to build the post-reset zeroing sequencer.
module bp_be_nr_regfile #(
  parameter int reg_addr_width_p = 5,
  parameter int dword_width_p    = 64,
  parameter int num_rs_p         = 3,
  parameter int data_width_p     = dword_width_p,
  parameter bit zero_x0_p        = 1'b0
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  output logic                             ready_o,
  input  logic                             cfg_v_i,
  input  logic                             cfg_w_i,
  input  logic [reg_addr_width_p-1:0]      cfg_addr_i,
  input  logic [data_width_p-1:0]          cfg_data_i,
  output logic                             cfg_yumi_o,
  output logic                             cfg_data_v_o,
  output logic [data_width_p-1:0]          cfg_data_o,
  input  logic                             rd_w_v_i,
  input  logic [reg_addr_width_p-1:0]      rd_addr_i,
  input  logic [data_width_p-1:0]          rd_data_i,
  input  logic [num_rs_p-1:0]              rs_r_v_i,
  input  logic [num_rs_p*reg_addr_width_p-1:0] rs_addr_i,
  output logic [num_rs_p*data_width_p-1:0] rs_data_o
);

  localparam int AW     = reg_addr_width_p;
  localparam int DW     = data_width_p;
  localparam int els_lp = 2**AW;

  logic [DW-1:0]           mem_q [els_lp];
  logic [AW-1:0]           addr_q [num_rs_p];
  logic [AW-1:0]           addr_d [num_rs_p];
  logic [num_rs_p*DW-1:0]  rs_data_q, rs_data_d;
  logic [DW-1:0]           cfg_data_q, cfg_data_d;
  logic                    cfg_data_v_q;

  logic          ready;
  logic          scrub_v;
  logic [AW-1:0] scrub_addr;
  logic          pipe_w, cfg_w, cfg_r, w_v, w_en;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;

`ifdef BP_BE_NR_REGFILE_SCRUB_EN
  typedef enum logic {e_init, e_ready} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  // Scrub next state: walk every entry once, then park in e_ready
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == e_init) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) state_d = e_ready;
    end
  end

  // Scrub state and counter registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_init;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready      = (state_q == e_ready);
  assign scrub_v    = (state_q == e_init);
  assign scrub_addr = cnt_q;
`else
  assign ready      = 1'b1;
  assign scrub_v    = 1'b0;
  assign scrub_addr = '0;
`endif

  assign ready_o    = ready;
  assign cfg_yumi_o = cfg_v_i & ready & ~(cfg_w_i & rd_w_v_i);

  assign pipe_w = ready & rd_w_v_i;
  assign cfg_w  = cfg_yumi_o & cfg_w_i;
  assign cfg_r  = cfg_yumi_o & ~cfg_w_i;
  assign w_v    = pipe_w | cfg_w;
  assign w_addr = pipe_w ? rd_addr_i : cfg_addr_i;
  assign w_data = pipe_w ? rd_data_i : cfg_data_i;
  assign w_en   = w_v & ~(zero_x0_p && (w_addr == '0));

  // Read ports: pick effective address, then zero / forward / array
  always_comb begin
    addr_d    = addr_q;
    rs_data_d = '0;
    for (int k = 0; k < num_rs_p; k++) begin
      addr_d[k] = rs_r_v_i[k] ? rs_addr_i[k*AW +: AW] : addr_q[k];
      if (!ready || (zero_x0_p && (addr_d[k] == '0)))
        rs_data_d[k*DW +: DW] = '0;
      else if (w_en && (w_addr == addr_d[k]))
        rs_data_d[k*DW +: DW] = w_data;
      else
        rs_data_d[k*DW +: DW] = mem_q[addr_d[k]];
    end
  end

  // Config read value, forwarded from a same-cycle pipeline write
  always_comb begin
    cfg_data_d = mem_q[cfg_addr_i];
    if (zero_x0_p && (cfg_addr_i == '0))
      cfg_data_d = '0;
    else if (pipe_w && (rd_addr_i == cfg_addr_i))
      cfg_data_d = rd_data_i;
  end

  // Output and held-address registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rs_data_q    <= '0;
      cfg_data_q   <= '0;
      cfg_data_v_q <= 1'b0;
      for (int k = 0; k < num_rs_p; k++) addr_q[k] <= '0;
    end else begin
      rs_data_q    <= rs_data_d;
      addr_q       <= addr_d;
      cfg_data_v_q <= cfg_r;
      if (cfg_r) cfg_data_q <= cfg_data_d;
    end
  end

  // Storage array, no reset; scrub owns the write port while initialising
  always_ff @(posedge clk_i) begin
    if (scrub_v)
      mem_q[scrub_addr] <= '0;
    else if (w_en)
      mem_q[w_addr] <= w_data;
  end

  assign rs_data_o    = rs_data_q;
  assign cfg_data_o   = cfg_data_q;
  assign cfg_data_v_o = cfg_data_v_q;

endmodule

// File: tb/tb_bp_be_nr_regfile.sv
// Directed bench for bp_be_nr_regfile.
// Two instances share stimulus: x0 ordinary (u_dut) and x0 hardwired (u_zx).
module tb_bp_be_nr_regfile;

  localparam int AW = 5;
  localparam int DW = 64;
  localparam int NR = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic cfg_v, cfg_w;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_data;
  logic rd_w_v;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [NR-1:0] rs_r_v;
  logic [NR*AW-1:0] rs_addr;

  logic ready, zready, yumi, zyumi, cdv, zcdv;
  logic [DW-1:0] cdo, zcdo;
  logic [NR*DW-1:0] rs_o, zrs_o;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bp_be_nr_regfile #(
    .reg_addr_width_p(AW), .dword_width_p(DW),
    .num_rs_p(NR), .data_width_p(DW), .zero_x0_p(1'b0)
  ) u_dut (
    .clk_i(clk), .reset_n_i(rst_n), .ready_o(ready),
    .cfg_v_i(cfg_v), .cfg_w_i(cfg_w), .cfg_addr_i(cfg_addr),
    .cfg_data_i(cfg_data), .cfg_yumi_o(yumi),
    .cfg_data_v_o(cdv), .cfg_data_o(cdo),
    .rd_w_v_i(rd_w_v), .rd_addr_i(rd_addr), .rd_data_i(rd_data),
    .rs_r_v_i(rs_r_v), .rs_addr_i(rs_addr), .rs_data_o(rs_o)
  );

  bp_be_nr_regfile #(
    .reg_addr_width_p(AW), .dword_width_p(DW),
    .num_rs_p(NR), .data_width_p(DW), .zero_x0_p(1'b1)
  ) u_zx (
    .clk_i(clk), .reset_n_i(rst_n), .ready_o(zready),
    .cfg_v_i(cfg_v), .cfg_w_i(cfg_w), .cfg_addr_i(cfg_addr),
    .cfg_data_i(cfg_data), .cfg_yumi_o(zyumi),
    .cfg_data_v_o(zcdv), .cfg_data_o(zcdo),
    .rd_w_v_i(rd_w_v), .rd_addr_i(rd_addr), .rd_data_i(rd_data),
    .rs_r_v_i(rs_r_v), .rs_addr_i(rs_addr), .rs_data_o(zrs_o)
  );

  task automatic check_eq(input string tag,
                          input logic [191:0] got,
                          input logic [191:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cfg_v = 1'b0; cfg_w = 1'b0; cfg_addr = '0; cfg_data = '0;
    rd_w_v = 1'b0; rd_addr = '0; rd_data = '0;
    rs_r_v = '0; rs_addr = '0;
  endtask

  initial begin
    logic [AW-1:0] a5;
    int n;
    idle();
    rst_n = 1'b0;
    #12;
    check_eq("rst_rs", rs_o, '0);
    check_eq("rst_cdv", cdv, 0);
    check_eq("rst_cdo", cdo, 0);
    check_eq("rst_yumi", yumi, 0);
`ifdef BP_BE_NR_REGFILE_SCRUB_EN
    check_eq("rst_ready", ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check_eq("ready_mid", ready, 0);
    rst_n = 1'b0;
    #1;
    check_eq("ready_rst2", ready, 0);
    tick(); tick();
    rst_n = 1'b1;
    n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
    check_eq("scrub_len", n, 32);
    check_eq("zscrub_rdy", zready, 1);
    for (int a = 0; a < 32; a++) begin
      a5 = a[AW-1:0];
      rs_r_v = '1;
      rs_addr = {NR{a5}};
      tick();
      check_eq("scrub_zero", rs_o, '0);
      check_eq("zscrub_zero", zrs_o, '0);
    end
    idle();
`else
    check_eq("rst_ready", ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
`endif

    // stall re-read on port 1
    rs_r_v = 3'b010;
    rs_addr = {5'd0, 5'd7, 5'd0};
    tick();
    rs_r_v = '0;
    rs_addr = '0;
    rd_w_v = 1'b1; rd_addr = 5'd7; rd_data = 64'hDEAD_BEEF;
    tick();
    rd_w_v = 1'b0;
    check_eq("stall_fwd", rs_o[127:64], 64'hDEAD_BEEF);
    tick();
    check_eq("stall_hold", rs_o[127:64], 64'hDEAD_BEEF);

    // same-cycle forwarding on all ports
    rd_w_v = 1'b1; rd_addr = 5'd3; rd_data = 64'h1234;
    rs_r_v = '1; rs_addr = {5'd3, 5'd3, 5'd3};
    tick();
    idle();
    check_eq("fwd_all", rs_o, {3{64'h1234}});
    check_eq("zfwd_all", zrs_o, {3{64'h1234}});
    tick();
    check_eq("fwd_store", rs_o, {3{64'h1234}});

    // x0 behaviour
    rd_w_v = 1'b1; rd_addr = 5'd0; rd_data = 64'hFFFF;
    rs_r_v = '1; rs_addr = '0;
    tick();
    idle();
    check_eq("x0_fwd", rs_o, {3{64'hFFFF}});
    check_eq("zx0_fwd", zrs_o, '0);
    rs_r_v = '1;
    tick();
    rs_r_v = '0;
    check_eq("x0_read", rs_o, {3{64'hFFFF}});
    check_eq("zx0_read", zrs_o, '0);

    // config write collides with pipeline write
    cfg_v = 1'b1; cfg_w = 1'b1; cfg_addr = 5'd5; cfg_data = 64'hAAAA;
    rd_w_v = 1'b1; rd_addr = 5'd5; rd_data = 64'h5555;
    #1;
    check_eq("cw_block", yumi, 0);
    tick();
    rd_w_v = 1'b0;
    #1;
    check_eq("cw_retry", yumi, 1);
    tick();
    idle();

    // config read of 5
    cfg_v = 1'b1; cfg_w = 1'b0; cfg_addr = 5'd5;
    #1;
    check_eq("cr_yumi", yumi, 1);
    tick();
    idle();
    check_eq("cr_v", cdv, 1);
    check_eq("cr_data", cdo, 64'hAAAA);
    tick();
    check_eq("cr_v_drop", cdv, 0);
    check_eq("cr_hold", cdo, 64'hAAAA);
    rs_r_v = 3'b001; rs_addr = {5'd0, 5'd0, 5'd5};
    tick();
    idle();
    check_eq("cw_final", rs_o[63:0], 64'hAAAA);

    // config read racing a pipeline write to the same entry
    cfg_v = 1'b1; cfg_w = 1'b0; cfg_addr = 5'd5;
    rd_w_v = 1'b1; rd_addr = 5'd5; rd_data = 64'h77;
    #1;
    check_eq("crw_yumi", yumi, 1);
    tick();
    idle();
    check_eq("crw_v", cdv, 1);
    check_eq("crw_data", cdo, 64'h77);

    // config read of x0
    cfg_v = 1'b1; cfg_w = 1'b0; cfg_addr = 5'd0;
    tick();
    idle();
    check_eq("cr_x0", cdo, 64'hFFFF);
    check_eq("zcr_x0", zcdo, 0);

    // config write forwarded to a read port
    cfg_v = 1'b1; cfg_w = 1'b1; cfg_addr = 5'd9; cfg_data = 64'h99;
    rs_r_v = 3'b100; rs_addr = {5'd9, 5'd0, 5'd0};
    tick();
    idle();
    check_eq("cw_fwd", rs_o[191:128], 64'h99);

    // reset mid-operation drops pending read data
    cfg_v = 1'b1; cfg_w = 1'b0; cfg_addr = 5'd3;
    tick();
    idle();
    check_eq("pre_rst_v", cdv, 1);
    rst_n = 1'b0;
    #1;
    check_eq("rst2_cdv", cdv, 0);
    check_eq("rst2_cdo", cdo, 0);
    check_eq("rst2_rs", rs_o, '0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
